// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared widths and event bundle for the debouncer bank
package debounce_pkg;

  // $clog2 wrapper that still yields a usable 1-bit counter for n <= 1
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int MIN_CNT_W = 1;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold;
  } btn_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, stability filter and hold counter for one input
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 100,
  parameter int HOLD_TICKS   = 500
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  logic     btn,
  output btn_evt_t evt
);

  localparam int STAB_W = cnt_width(STABLE_TICKS);
  localparam int HOLD_W = cnt_width(HOLD_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic [STAB_W-1:0]      stab_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   accept;
  logic                   hold_clr;

  assign sync     = sync_ff[SYNC_STAGES-1];
  assign accept   = (sync != evt.level) && tick && (stab_cnt == STAB_W'(STABLE_TICKS - 1));
  // the press cycle also clears, so hold never lands on the press pulse
  assign hold_clr = !evt.level || evt.press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff  <= '0;
      stab_cnt <= '0;
      hold_cnt <= '0;
      evt      <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn};

      if (sync == evt.level || accept)
        stab_cnt <= '0;
      else if (tick)
        stab_cnt <= stab_cnt + 1'b1;

      if (accept)
        evt.level <= sync;
      evt.press <= accept && sync;
      evt.rel   <= accept && !sync;

      if (hold_clr)
        hold_cnt <= '0;
      else if (tick && hold_cnt != HOLD_W'(HOLD_TICKS))
        hold_cnt <= hold_cnt + 1'b1;
      evt.hold <= !hold_clr && tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
    end
  end

endmodule

// File: rtl/button_debounce_bank.sv
// rtl/button_debounce_bank.sv - shared prescaler driving a bank of debounce channels
module button_debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 100,
  parameter int HOLD_TICKS   = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_hold
);

  localparam int DIV_W = cnt_width(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  btn_evt_t         evt [CHANNELS];

  // with TICK_DIV=1 the compare is against 0 and div_cnt never leaves 0
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .btn  (btn_in[i]),
      .evt  (evt[i])
    );

    assign btn_level[i]   = evt[i].level;
    assign btn_press[i]   = evt[i].press;
    assign btn_release[i] = evt[i].rel;
    assign btn_hold[i]    = evt[i].hold;
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// tb/tb_button_debounce_bank.sv - directed self-checking bench for button_debounce_bank
module tb_button_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_in, a_level, a_press, a_rel, a_hold;
  logic [0:0] b_in, b_level, b_press, b_rel, b_hold;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [3:0] press_acc, rel_acc, hold_acc, lvl_acc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  button_debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4), .HOLD_TICKS(10)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_in(a_in), .btn_level(a_level),
    .btn_press(a_press), .btn_release(a_rel), .btn_hold(a_hold)
  );

  button_debounce_bank #(
    .CHANNELS(1), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3), .HOLD_TICKS(5)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_in(b_in), .btn_level(b_level),
    .btn_press(b_press), .btn_release(b_rel), .btn_hold(b_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      press_acc |= a_press;
      rel_acc   |= a_rel;
      hold_acc  |= a_hold;
      lvl_acc   |= a_level;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, j, n, w;
    press_acc = '0; rel_acc = '0; hold_acc = '0; lvl_acc = '0;
    reset = 1'b1; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", a_level, 4'h0);
    chk("rst_pulses", {a_press, a_rel, a_hold}, 12'h000);

    // reset mid-operation with all inputs high, then re-qualification
    reset = 1'b0; a_in = 4'hF;
    tick_n(8);
    chk("pre_rst_level", a_level, 4'hF);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_level", a_level, 4'h0);
    chk("async_rst_pulses", {a_press, a_rel, a_hold}, 12'h000);
    @(posedge clk);
    #1 reset = 1'b0;
    tick_n(5);
    chk("requal_edge5", a_level, 4'h0);
    tick_n(1);
    chk("requal_edge6_level", a_level, 4'hF);
    chk("requal_edge6_press", a_press, 4'hF);
    tick_n(1);
    chk("requal_press_width", a_press, 4'h0);

    // early release: release pulse, hold suppressed
    hold_acc = '0; a_in = 4'h0;
    tick_n(5);
    chk("rel_edge5", a_level, 4'hF);
    tick_n(1);
    chk("rel_edge6_level", a_level, 4'h0);
    chk("rel_edge6_pulse", a_rel, 4'hF);
    tick_n(1);
    chk("rel_width", a_rel, 4'h0);
    chk("hold_suppressed", hold_acc, 4'h0);

    // clean press on ch0, hold at HOLD_TICKS after press cycle, release
    tick_n(3);
    a_in = 4'h1;
    tick_n(5);
    chk("ch0_edge5", a_level, 4'h0);
    tick_n(1);
    chk("ch0_press_level", a_level, 4'h1);
    chk("ch0_press", a_press, 4'h1);
    tick_n(10);
    chk("hold_edge16", a_hold, 4'h0);
    tick_n(1);
    chk("hold_edge17", a_hold, 4'h1);
    tick_n(1);
    chk("hold_width", a_hold, 4'h0);
    tick_n(2);
    a_in = 4'h0;
    tick_n(5);
    chk("ch0_rel_edge5", a_level, 4'h1);
    tick_n(1);
    chk("ch0_rel_level", a_level, 4'h0);
    chk("ch0_release", a_rel, 4'h1);
    tick_n(1);
    chk("ch0_rel_width", a_rel, 4'h0);

    // short press of 8 cycles: no hold
    tick_n(3);
    hold_acc = '0; press_acc = '0;
    a_in = 4'h1;
    tick_n(8);
    a_in = 4'h0;
    tick_n(12);
    chk("short_press_seen", press_acc, 4'h1);
    chk("short_no_hold", hold_acc, 4'h0);
    chk("short_level_back", a_level, 4'h0);

    // bounce on ch1: 3 high, 1 low, 3 high, low
    lvl_acc = '0; press_acc = '0;
    a_in = 4'h2; tick_n(3);
    a_in = 4'h0; tick_n(1);
    a_in = 4'h2; tick_n(3);
    a_in = 4'h0; tick_n(8);
    chk("bounce_level", lvl_acc, 4'h0);
    chk("bounce_press", press_acc, 4'h0);
    a_in = 4'h2; tick_n(4);
    a_in = 4'h0; tick_n(2);
    chk("stable4_level", a_level, 4'h2);
    chk("stable4_press", a_press, 4'h2);
    tick_n(4);
    chk("stable4_release", a_rel, 4'h2);

    // prescaler phase sweep on dut_b
    for (int p = 0; p < 4; p++) begin
      w = 0;
      while ((cyc % 4) != p && w < 4) begin
        tick_n(1);
        w++;
      end
      b_in = 1'b1;
      e = cyc;
      j = 3;
      while (((e + j - 1) % 4) != 3) j++;
      n = 0;
      while (!b_level[0] && n < 40) begin
        tick_n(1);
        n++;
      end
      chk($sformatf("phase%0d_latency", p), n, j + 8);
      chk($sformatf("phase%0d_range", p), (n >= 11 && n <= 15), 1);
      b_in = 1'b0;
      n = 0;
      while (b_level[0] && n < 40) begin
        tick_n(1);
        n++;
      end
      chk($sformatf("phase%0d_fall", p), b_level, 1'b0);
    end

    // simultaneous steps on ch0/ch3 while ch2 bounces
    tick_n(2);
    lvl_acc = '0;
    for (int k = 0; k < 5; k++) begin
      a_in = 4'b1001 | (((k % 3) != 2) ? 4'b0100 : 4'b0000);
      tick_n(1);
    end
    chk("multi_edge5", a_level, 4'h0);
    a_in = 4'b1001;
    tick_n(1);
    chk("multi_press", a_press, 4'b1001);
    chk("multi_level", a_level, 4'b1001);
    for (int k = 0; k < 6; k++) begin
      a_in = 4'b1001 | (((k % 3) != 2) ? 4'b0100 : 4'b0000);
      tick_n(1);
    end
    chk("ch2_stays_low", lvl_acc & 4'b0100, 4'h0);

    // reset mid-count aborts pending release (ch0/ch3) and press (ch1)
    a_in = 4'b0010;
    tick_n(3);
    #2 reset = 1'b1;
    #1;
    chk("midcount_rst_level", a_level, 4'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rel_acc = '0;
    tick_n(5);
    chk("midcount_edge5", a_level, 4'h0);
    chk("midcount_no_release", rel_acc, 4'h0);
    tick_n(1);
    chk("midcount_requal_level", a_level, 4'h2);
    chk("midcount_requal_press", a_press, 4'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce_bank.md
# button_debounce_bank

Parametrised multi-channel debouncer for raw mechanical inputs such as push buttons and switches. Each channel has an input synchronizer, a stability filter driven by a shared prescaler tick, a clean level output, one-cycle press/release pulses and a long-press (hold) pulse. It sits between the board pins and the control FSMs, and replaces single-channel, cycle-counted debouncing.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent inputs; ≥1.
- `SYNC_STAGES`, 2: synchronizer flops per channel; ≥2.
- `TICK_DIV`, 1000: clock cycles per filter tick; ≥1 (1 means a tick every cycle).
- `STABLE_TICKS`, 100: consecutive ticks an input must differ from `btn_level` before `btn_level` accepts it; ≥1.
- `HOLD_TICKS`, 500: ticks `btn_level` must stay high before `btn_hold` fires; ≥1.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `btn_in`, in, CHANNELS: raw asynchronous inputs; active-high.
- `btn_level`, out, CHANNELS: debounced level per channel.
- `btn_press`, out, CHANNELS: one-cycle pulse when `btn_level` rises.
- `btn_release`, out, CHANNELS: one-cycle pulse when `btn_level` falls.
- `btn_hold`, out, CHANNELS: one-cycle pulse when a press has lasted `HOLD_TICKS` ticks.

## Operation
- **Reset values:** all outputs 0; synchronizer flops 0; prescaler 0; all counters 0.
- **Prescaler:**
  - `div_cnt` runs 0…TICK_DIV-1 and wraps to 0.
  - `tick` = (`div_cnt` == TICK_DIV-1), registered-free compare.
  - With TICK_DIV=1, `tick` is constantly 1.
  - One prescaler is shared by all channels.
- **Synchronizer:** `btn_in[i]` passes through SYNC_STAGES flops to give `sync[i]`. Only `sync[i]` is used downstream.
- **Stability filter, per channel** (counter `stab_cnt`, width $clog2(STABLE_TICKS)):
  - `sync` == `btn_level`: `stab_cnt` ← 0 on every cycle, tick or not.
  - `sync` != `btn_level` and `tick` and `stab_cnt` < STABLE_TICKS-1: `stab_cnt` increments.
  - `sync` != `btn_level` and `tick` and `stab_cnt` == STABLE_TICKS-1:
    - `btn_level` ← `sync`; `stab_cnt` ← 0.
    - If the new level is 1, `btn_press` pulses; if 0, `btn_release` pulses.
  - Any reversion of `sync` before acceptance discards the accumulated count.
- **Hold detection, per channel** (counter `hold_cnt`, width $clog2(HOLD_TICKS+1)):
  - Cleared whenever `btn_level` is 0, and in the cycle `btn_press` is asserted.
  - While `btn_level` is 1, increments on each `tick` until it saturates at HOLD_TICKS.
  - `btn_hold` pulses in the single cycle where `hold_cnt` goes from HOLD_TICKS-1 to HOLD_TICKS. It fires once per press, with no auto-repeat.
  - A release before saturation suppresses `btn_hold`.
- **Pulse exclusivity:** press and release are mutually exclusive on a channel. `btn_hold` never coincides with `btn_press`, including when HOLD_TICKS=1: hold then fires on the first tick after the press cycle.
- **Channel independence:** simultaneous events on several channels are all reported in the same cycle.
- **Reset mid-operation:** all counts are discarded. An input held high across reset is re-qualified afterwards and produces a fresh `btn_press`.

## Timing
- All outputs are registered.
- **Latency with TICK_DIV=1:** take edge 1 as the first edge that samples a new `btn_in`. `btn_level` and the press/release pulse are valid after edge SYNC_STAGES+STABLE_TICKS.
- **Latency with TICK_DIV>1:** latency is SYNC_STAGES + 1 cycle + between (STABLE_TICKS-1)·TICK_DIV and STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- **Pulse width:** exactly one clock cycle.
- **Hold timing:** `btn_hold` is asserted on the HOLD_TICKS-th tick edge after the `btn_press` cycle.

## Structure
- **Package `debounce_pkg`:**
  - `localparam` helpers for counter widths (`$clog2` wrappers that tolerate a value of 1).
  - A typedef `btn_evt_t` struct holding level, press, release and hold.
- **Top `button_debounce_bank`:** contains the prescaler and a generate loop instantiating `debounce_channel` CHANNELS times.
- **Sub-module `debounce_channel`:** synchronizer, stability filter and hold counter for one input. It takes `tick` as an input.

## Test plan
1. **Reset values:** assert `reset` mid-simulation with all `btn_in` = 1 → all outputs 0 immediately. After release, with TICK_DIV=1, SYNC_STAGES=2, STABLE_TICKS=4, `btn_level` rises at edge 6 and `btn_press` pulses once.
2. **Clean press and release:** same parameters, step channel 0 from 0→1, hold 20 cycles, then 1→0.
   - `btn_level[0]` rises 6 edges after the step; one `btn_press` pulse.
   - Falls 6 edges after the release step; one `btn_release` pulse.
3. **Bounce rejection:** STABLE_TICKS=4; pulse `btn_in[1]` high for 3 cycles, low for 1, high for 3, then low → no change on any output. Follow with a 4-cycle-stable high → accepted.
4. **Hold:** HOLD_TICKS=10, TICK_DIV=1; hold a button for 30 cycles.
   - `btn_hold` pulses exactly once, 10 edges after the `btn_press` cycle.
   - A second press of 8 cycles produces no `btn_hold`.
5. **Prescaler phase:** TICK_DIV=4, STABLE_TICKS=3; apply input steps at each of the 4 prescaler phases → measured latency is within 2+1+[8,12] cycles in every case.
6. **Channel independence:** CHANNELS=4; apply simultaneous steps on channels 0 and 3 while channel 2 bounces.
   - Channels 0 and 3 pulse `btn_press` in the same cycle.
   - Channel 2 stays 0.
   - Asserting reset mid-count aborts every pending transition.
